// File: rtl/timebase_pkg.sv
// timebase_pkg: shared channel limits and 100 MHz terminal counts for the timebase generator
package timebase_pkg;

    localparam int TB_MAX_CH      = 8;
    localparam int TB_DEF_TC_1HZ  = 49_999_999;
    localparam int TB_DEF_TC_2HZ  = 24_999_999;
    localparam int TB_DEF_TC_1KHZ = 49_999;

    typedef enum logic [1:0] {
        CH_HOLD,
        CH_COUNT,
        CH_WRAP,
        CH_CLEAR
    } ch_action_e;

    // Decide what a channel does this cycle; clear beats wrap beats plain advance
    function automatic ch_action_e ch_action(input logic clr, input logic adv, input logic at_tc);
        return clr ? CH_CLEAR : (adv & at_tc) ? CH_WRAP : adv ? CH_COUNT : CH_HOLD;
    endfunction

endpackage

// File: rtl/timebase_channel.sv
// timebase_channel: one programmable divider with tick strobe and 50% wave
module timebase_channel
    import timebase_pkg::*;
#(
    parameter int               CNT_W  = 32,
    parameter logic [CNT_W-1:0] DEF_TC = CNT_W'(TB_DEF_TC_2HZ)
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [CNT_W-1:0] tc_in,
    output logic             tick,
    output logic             wave,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tc_q;
    ch_action_e       act;

    assign wrap = adv & (cnt == tc_q);
    assign act  = ch_action(clr, adv, cnt == tc_q);

    // Count advancing cycles; at wrap restart, toggle wave, strobe tick and take the next period's tc
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tc_q <= DEF_TC;
            tick <= 1'b0;
            wave <= 1'b0;
        end else begin
            cnt  <= (act == CH_COUNT) ? cnt + CNT_W'(1) : (act == CH_HOLD) ? cnt : '0;
            tc_q <= (act == CH_CLEAR || act == CH_WRAP) ? tc_in : tc_q;
            tick <= (act == CH_WRAP);
            wave <= (act == CH_CLEAR) ? 1'b0 : (act == CH_WRAP) ? ~wave : wave;
        end
    end

endmodule

// File: rtl/timebase_gen.sv
// timebase_gen: multi-channel programmable tick/wave generator; TIMEBASE_CASCADE_EN chains channel k to wraps of k-1
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int               NUM_CH = 4,
    parameter int               CNT_W  = 32,
    parameter logic [CNT_W-1:0] DEF_TC = CNT_W'(TB_DEF_TC_2HZ)
) (
    input  logic                    clk_100MHz,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    sync_clr,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] tc,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       wave
);

    logic [NUM_CH-1:0] src;
    logic [NUM_CH-1:0] adv;
    logic [NUM_CH-1:0] wrap;
    logic              unused_wrap;

    assign unused_wrap = ^wrap;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
`ifdef TIMEBASE_CASCADE_EN
        if (k == 0) begin : g_head
            assign src[k] = 1'b1;
        end else begin : g_link
            assign src[k] = wrap[k-1];
        end
`else
        assign src[k] = 1'b1;
`endif
        assign adv[k] = en & ch_en[k] & src[k];

        timebase_channel #(
            .CNT_W  (CNT_W),
            .DEF_TC (DEF_TC)
        ) u_ch (
            .clk_100MHz (clk_100MHz),
            .reset_n    (reset_n),
            .clr        (sync_clr),
            .adv        (adv[k]),
            .tc_in      (tc[k*CNT_W +: CNT_W]),
            .tick       (tick[k]),
            .wave       (wave[k]),
            .wrap       (wrap[k])
        );
    end

endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: directed and random checks of timebase_gen against a period-based reference model
module tb_timebase_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int DEF_TC = 7;
`ifdef TIMEBASE_CASCADE_EN
    localparam bit CASC = 1'b1;
`else
    localparam bit CASC = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0;
    logic                    sync_clr = 1'b0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic [NUM_CH*CNT_W-1:0] tc = '0;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       wave;

    int n_chk = 0;
    int n_fail = 0;

    // Model: advances done in the current period, period length, expected tick and wave
    int m_n[NUM_CH];
    int m_per[NUM_CH];
    bit m_tk[NUM_CH];
    bit m_wv[NUM_CH];

    timebase_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_TC (8'(DEF_TC))
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (rst_n),
        .en         (en),
        .sync_clr   (sync_clr),
        .ch_en      (ch_en),
        .tc         (tc),
        .tick       (tick),
        .wave       (wave)
    );

    always #5 clk = ~clk;

    task automatic check_all();
        for (int k = 0; k < NUM_CH; k++) begin
            n_chk++;
            assert (tick[k] === m_tk[k]) else begin
                n_fail++;
                $error("FAIL tick%0d t=%0t observed=%b expected=%b", k, $time, tick[k], m_tk[k]);
            end
            n_chk++;
            assert (wave[k] === m_wv[k]) else begin
                n_fail++;
                $error("FAIL wave%0d t=%0t observed=%b expected=%b", k, $time, wave[k], m_wv[k]);
            end
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_tc(input int k, input int v);
        tc[k*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // One clock: predict from current inputs, take the edge, compare #1 later
    task automatic step();
        bit prev = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            int tcv = int'(tc[k*CNT_W +: CNT_W]);
            bit a = en && ch_en[k] && (CASC ? prev : 1'b1);
            bit w = a && (m_n[k] + 1 == m_per[k]);
            prev = w;
            if (sync_clr) begin
                m_n[k] = 0; m_wv[k] = 1'b0; m_tk[k] = 1'b0; m_per[k] = tcv + 1;
            end else if (w) begin
                m_n[k] = 0; m_wv[k] = ~m_wv[k]; m_tk[k] = 1'b1; m_per[k] = tcv + 1;
            end else begin
                m_tk[k] = 1'b0;
                if (a) m_n[k]++;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_n[k] = 0; m_per[k] = DEF_TC + 1; m_tk[k] = 1'b0; m_wv[k] = 1'b0;
        end
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Clocks until channel ch ticks; -1 if it never does within the budget
    task automatic wait_tick(input int ch, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (!tick[ch] && c < 600);
        if (!tick[ch]) c = -1;
    endtask

    initial begin
        int c;
        en = 1'b1;
        ch_en = '1;
        set_tc(0, 4); set_tc(1, 4); set_tc(2, 6); set_tc(3, 255);
        @(posedge clk);
        #1;
        do_reset();
        wait_tick(0, c); chk_int("first_tick_def_tc", c, DEF_TC + 1);
        wait_tick(0, c); chk_int("period_tc4", c, 5);
        step(); step();
        set_tc(0, 9);
        wait_tick(0, c); chk_int("cur_period_kept", c, 3);
        wait_tick(0, c); chk_int("period_tc9", c, 10);
        set_tc(0, 0);
        wait_tick(0, c); chk_int("last_period_tc9", c, 10);
        wait_tick(0, c); chk_int("period_tc0", c, 1);
        repeat (4) step();
        en = 1'b0;
        repeat (3) step();
        chk_int("en_off_tick", int'(tick[0]), 0);
        en = 1'b1;
        set_tc(0, 4);
        wait_tick(0, c); chk_int("tc0_reload", c, 1);
        repeat (3) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk_int("clr_tick", int'(tick[0]), 0);
        chk_int("clr_wave", int'(wave[0]), 0);
        wait_tick(0, c); chk_int("after_clr", c, 5);
        step(); step();
        do_reset();
        chk_int("reset_wave", int'(wave[0]), 0);
        wait_tick(0, c); chk_int("period_def_tc", c, DEF_TC + 1);
        set_tc(0, 3); set_tc(1, 2);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        wait_tick(1, c); chk_int("tick1_first", c, CASC ? 12 : 3);
        chk_int("tick1_with_tick0", int'(tick[0]), CASC ? 1 : 0);
        wait_tick(1, c); chk_int("tick1_period", c, CASC ? 12 : 3);
        set_tc(0, 255);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        wait_tick(0, c); chk_int("all_ones_period", c, 256);
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(7) != 0);
            ch_en = NUM_CH'($urandom | $urandom);
            if ($urandom_range(7) == 0)
                set_tc(int'($urandom_range(NUM_CH - 1)), ($urandom_range(15) == 0) ? 255 : int'($urandom_range(5)));
            sync_clr = ($urandom_range(49) == 0);
            if ($urandom_range(199) == 0) begin
                sync_clr = 1'b0;
                do_reset();
            end else
                step();
        end
        sync_clr = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
